// File: rtl/matrix_mac_datapath_pkg.sv
//------------------------------------------------------------------------------
// matrix_mac_datapath_pkg : shared widths and FSM state encodings for the
//                           matrix-multiply control/datapath pair.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package matrix_mac_datapath_pkg;

  localparam int DATA_W    = 8;
  localparam int N_ENTRIES = 8;
  localparam int CNT_W     = 4;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int ACC_W     = 2 * DATA_W + 3;
  localparam int OUT_W     = 2 * DATA_W;

  // Encoding shared with the upstream control FSM
  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_MULTIPLY   = 2'b01,
    ST_ACCUMULATE = 2'b10,
    ST_STORE      = 2'b11
  } mm_state_e;

endpackage

`default_nettype wire

// File: rtl/matrix_mac_datapath_if.sv
//------------------------------------------------------------------------------
// matrix_mac_datapath_if : FSM-to-datapath control strobes, operands and results.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface matrix_mac_datapath_if;
  import matrix_mac_datapath_pkg::*;

  logic                     load_matrix;
  logic                     multiply_matrix;
  logic                     add;
  logic                     done;
  logic signed [DATA_W-1:0] a_entry;
  logic signed [DATA_W-1:0] b_entry;
  logic [CNT_W-1:0]         entry_count;
  logic signed [OUT_W-1:0]  result;
  logic                     result_valid;

  modport master (
    output load_matrix, multiply_matrix, add, done, a_entry, b_entry,
    input  entry_count, result, result_valid
  );

  modport slave (
    input  load_matrix, multiply_matrix, add, done, a_entry, b_entry,
    output entry_count, result, result_valid
  );

endinterface

`default_nettype wire

// File: rtl/matrix_mac_datapath_product_adder_tree.sv
//------------------------------------------------------------------------------
// product_adder_tree : combinational signed sum of all stored products,
//                      sign-extended to the accumulator width.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module product_adder_tree
  import matrix_mac_datapath_pkg::*;
#(
  parameter int N_TERMS = N_ENTRIES,
  parameter int TERM_W  = PROD_W,
  parameter int SUM_W   = ACC_W
) (
  input  logic [N_TERMS-1:0][TERM_W-1:0] products,
  output logic signed [SUM_W-1:0]        sum
);

  logic signed [SUM_W-1:0] w_ext [N_TERMS];

  for (genvar i = 0; i < N_TERMS; i++) begin : g_sign_ext
    assign w_ext[i] = SUM_W'($signed(products[i]));
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      sum = sum + w_ext[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/matrix_mac_datapath.sv
//------------------------------------------------------------------------------
// matrix_mac_datapath : captures 8 signed A/B pairs, accumulates their dot
//                       product and registers it. Optional MAC_SATURATE_EN clamps.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module matrix_mac_datapath
  import matrix_mac_datapath_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  matrix_mac_datapath_if.slave bus
);

  logic [CNT_W-1:0]                 r_entry_count;
  logic [N_ENTRIES-1:0][PROD_W-1:0] r_prod;
  logic signed [ACC_W-1:0]          r_acc;
  logic signed [OUT_W-1:0]          r_result;
  logic                             r_result_valid;

  logic signed [PROD_W-1:0] w_a_ext;
  logic signed [PROD_W-1:0] w_b_ext;
  logic signed [PROD_W-1:0] w_product;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [OUT_W-1:0]  w_result;
  logic                     w_capture;

  // Operands fit in PROD_W after the product, so the low half is exact
  assign w_a_ext   = PROD_W'(bus.a_entry);
  assign w_b_ext   = PROD_W'(bus.b_entry);
  assign w_product = w_a_ext * w_b_ext;
  assign w_capture = bus.load_matrix && bus.multiply_matrix;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_entry_count <= '0;
      r_prod        <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (r_entry_count == CNT_W'(i)) begin
          r_prod[i] <= w_product;
        end
      end
      r_entry_count <= (r_entry_count == CNT_W'(N_ENTRIES - 1)) ?
                       '0 : r_entry_count + CNT_W'(1);
    end else if (!bus.multiply_matrix) begin
      r_entry_count <= '0;
    end
  end

  product_adder_tree #(
    .N_TERMS (N_ENTRIES),
    .TERM_W  (PROD_W),
    .SUM_W   (ACC_W)
  ) u_adder_tree (
    .products (r_prod),
    .sum      (w_sum)
  );

`ifdef MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] C_OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] C_OUT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

  always_comb begin
    w_result = r_acc[OUT_W-1:0];
    if (r_acc > C_OUT_MAX) begin
      w_result = OUT_W'(C_OUT_MAX);
    end else if (r_acc < C_OUT_MIN) begin
      w_result = OUT_W'(C_OUT_MIN);
    end
  end
`else
  logic w_unused_acc_hi;

  assign w_unused_acc_hi = ^r_acc[ACC_W-1:OUT_W];
  assign w_result        = r_acc[OUT_W-1:0];
`endif

  // Store reads r_acc from before the edge, so add and done may coincide
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      if (bus.add) begin
        r_acc <= w_sum;
      end
      if (bus.done) begin
        r_result <= w_result;
      end
      r_result_valid <= bus.done;
    end
  end

  assign bus.entry_count  = r_entry_count;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;

endmodule

`default_nettype wire

// File: tb/tb_matrix_mac_datapath.sv
//------------------------------------------------------------------------------
// tb_matrix_mac_datapath : directed and randomized runs against a transaction
//                          model of the dot-product datapath.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_matrix_mac_datapath;
  import matrix_mac_datapath_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  matrix_mac_datapath_if bus();

  matrix_mac_datapath dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests  = 0;
  int n_failed = 0;

  int     m_count;
  longint m_prod [N_ENTRIES];
  longint m_acc;
  longint m_result;
  bit     m_valid;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Signed OUT_W view of an arbitrary dot product
  function automatic longint reduce_acc(input longint acc);
    longint lim;
    longint m;
    lim = longint'(1) << (OUT_W - 1);
`ifdef MAC_SATURATE_EN
    if (acc > lim - 1) return lim - 1;
    if (acc < -lim)    return -lim;
    return acc;
`else
    m = acc % (2 * lim);
    if (m < 0)    m += 2 * lim;
    if (m >= lim) m -= 2 * lim;
    return m;
`endif
  endfunction

  function automatic longint dot(input int av[N_ENTRIES], input int bv[N_ENTRIES]);
    longint s = 0;
    for (int i = 0; i < N_ENTRIES; i++) s += longint'(av[i]) * longint'(bv[i]);
    return s;
  endfunction

  // One clock: drive inputs, advance the model, compare all outputs
  task automatic step(input bit rst, input bit ld, input bit mul, input bit ad,
                      input bit dn, input int a, input int b);
    longint sum;
    reset               = rst;
    bus.load_matrix     = ld;
    bus.multiply_matrix = mul;
    bus.add             = ad;
    bus.done            = dn;
    bus.a_entry         = DATA_W'(a);
    bus.b_entry         = DATA_W'(b);
    @(posedge clock);
    if (rst) begin
      m_count  = 0;
      foreach (m_prod[i]) m_prod[i] = 0;
      m_acc    = 0;
      m_result = 0;
      m_valid  = 0;
    end else begin
      sum = 0;
      foreach (m_prod[i]) sum += m_prod[i];
      if (dn) m_result = reduce_acc(m_acc);
      m_valid = dn;
      if (ad) m_acc = sum;
      if (mul && ld) begin
        m_prod[m_count] = longint'(a) * longint'(b);
        m_count = (m_count + 1) % N_ENTRIES;
      end else if (!mul) begin
        m_count = 0;
      end
    end
    #1;
    check_val("entry_count", longint'(bus.entry_count), m_count);
    check_val("result", longint'(bus.result), m_result);
    check_val("result_valid", longint'(bus.result_valid), longint'(m_valid));
  endtask

  task automatic run(input int av[N_ENTRIES], input int bv[N_ENTRIES]);
    for (int i = 0; i < N_ENTRIES; i++) step(0, 1, 1, 0, 0, av[i], bv[i]);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check_val("valid_latency", longint'(bus.result_valid), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check_val("valid_pulse_end", longint'(bus.result_valid), 0);
  endtask

  int av [N_ENTRIES];
  int bv [N_ENTRIES];
  int av2[N_ENTRIES];

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check_val("rst_entry_count", longint'(bus.entry_count), 0);
    check_val("rst_result", longint'(bus.result), 0);
    check_val("rst_valid", longint'(bus.result_valid), 0);

    // Add with nothing captured sums zero products
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check_val("empty_sum", longint'(bus.result), 0);

    for (int i = 0; i < N_ENTRIES; i++) begin av[i] = i + 1; bv[i] = 1; end
    run(av, bv);
    check_val("dot_1to8", longint'(bus.result), 36);

    for (int i = 0; i < N_ENTRIES; i++) begin av[i] = -128; bv[i] = -128; end
    run(av, bv);
`ifdef MAC_SATURATE_EN
    check_val("full_scale", longint'(bus.result), 32767);
`else
    check_val("full_scale", longint'(bus.result), 0);
`endif

    for (int i = 0; i < N_ENTRIES; i++) begin av[i] = 5; bv[i] = -3; end
    run(av, bv);
    check_val("dot_5x-3", longint'(bus.result), -120);
    for (int i = 0; i < N_ENTRIES; i++) begin av[i] = 2; bv[i] = 2; end
    run(av, bv);
    check_val("dot_2x2", longint'(bus.result), 32);

    // Reset lands during capture index 4
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, $urandom_range(255) - 128, 7);
    step(1, 1, 1, 0, 0, 11, 11);
    check_val("midrun_rst_count", longint'(bus.entry_count), 0);
    check_val("midrun_rst_result", longint'(bus.result), 0);
    check_val("midrun_rst_valid", longint'(bus.result_valid), 0);
    for (int i = 0; i < N_ENTRIES; i++) begin
      av[i] = int'($urandom_range(255)) - 128;
      bv[i] = int'($urandom_range(255)) - 128;
    end
    run(av, bv);
    check_val("fresh_run", longint'(bus.result), reduce_acc(dot(av, bv)));

    // Two-cycle load gap inside Multiply
    for (int i = 0; i < N_ENTRIES; i++) begin
      av[i] = int'($urandom_range(255)) - 128;
      bv[i] = int'($urandom_range(255)) - 128;
    end
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (i == 3) begin
        step(0, 0, 1, 0, 0, 99, 99);
        check_val("gap_hold", longint'(bus.entry_count), 3);
        step(0, 0, 1, 0, 0, -99, 99);
      end
      step(0, 1, 1, 0, 0, av[i], bv[i]);
    end
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check_val("gap_run", longint'(bus.result), reduce_acc(dot(av, bv)));

    // add and done in the same cycle, then a second done
    for (int i = 0; i < N_ENTRIES; i++) begin
      av[i]  = int'($urandom_range(255)) - 128;
      av2[i] = int'($urandom_range(255)) - 128;
      bv[i]  = int'($urandom_range(255)) - 128;
    end
    run(av, bv);
    for (int i = 0; i < N_ENTRIES; i++) step(0, 1, 1, 0, 0, av2[i], bv[i]);
    step(0, 0, 0, 1, 1, 0, 0);
    check_val("add_done_prior", longint'(bus.result), reduce_acc(dot(av, bv)));
    step(0, 0, 0, 0, 1, 0, 0);
    check_val("add_done_new", longint'(bus.result), reduce_acc(dot(av2, bv)));
    step(0, 0, 0, 0, 1, 0, 0);
    check_val("done_repeat_valid", longint'(bus.result_valid), 1);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        av[i] = int'($urandom_range(255)) - 128;
        bv[i] = int'($urandom_range(255)) - 128;
      end
      run(av, bv);
      check_val("random_run", longint'(bus.result), reduce_acc(dot(av, bv)));
    end

    for (int c = 0; c < 300; c++) begin
      step(($urandom_range(31) == 0), $urandom_range(1), ($urandom_range(3) != 0),
           ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

`default_nettype wire
